mux_l2_tx: RTL and testbench

MUX_L2_TX -- requirements
Module: mux_l2_tx

---
 rtl/mux_l2_pkg.sv | 15 +
 rtl/idle_detector.sv | 40 ++++
 rtl/mux_l2_tx.sv | 68 ++++++
 tb/tb_mux_l2_tx.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mux_l2_pkg.sv
// Shared defaults, constants and types for the two-lane interleaving transmitter.
package mux_l2_pkg;

  localparam int unsigned WIDTH_DEFAULT      = 8;
  localparam int unsigned IDLE_PAIRS_DEFAULT = 4;

  // Byte driven whenever the emitted lane is not valid
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  typedef enum logic {
    PhCapture = 1'b0,
    PhEmit    = 1'b1
  } phase_e;

endpackage

// File: rtl/idle_detector.sv
// Saturating count of consecutive all-invalid pairs; idle is flagged once the count saturates.
module idle_detector
  import mux_l2_pkg::*;
#(
  parameter int unsigned IDLE_PAIRS = IDLE_PAIRS_DEFAULT
) (
  input  logic clk_4f,
  input  logic reset,
  input  logic strobe,
  input  logic active,
  output logic idle
);

  localparam int unsigned CntW = $clog2(IDLE_PAIRS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(IDLE_PAIRS);

  logic [CntW-1:0] ic_q;
  logic [CntW-1:0] ic_d;

  always_comb begin
    ic_d = ic_q;
    if (active) begin
      ic_d = '0;
    end else if (ic_q != CntMax) begin
      ic_d = ic_q + 1'b1;
    end
  end

  // Counter and flag only move on the capture edge; held otherwise
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      ic_q <= CntMax;
      idle <= 1'b1;
    end else if (strobe) begin
      ic_q <= ic_d;
      idle <= (ic_d == CntMax);
    end
  end

endmodule

// File: rtl/mux_l2_tx.sv
// Two-lane to one-stream interleaver: lane 0 emitted on the capture edge, lane 1 one edge later.
module mux_l2_tx
  import mux_l2_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEFAULT,
  parameter int unsigned IDLE_PAIRS = IDLE_PAIRS_DEFAULT
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in0,
  input  logic             valid_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             valid_in1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             lane_out,
  output logic             idle_out
);

  localparam logic [WIDTH-1:0] IdleWord = WIDTH'(IDLE_BYTE);

  phase_e           phase_q;
  logic [WIDTH-1:0] hold1_data_q;
  logic             hold1_valid_q;
  logic             capture;

  assign capture = (phase_q == PhCapture);

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      phase_q       <= PhCapture;
      data_out      <= IdleWord;
      valid_out     <= 1'b0;
      lane_out      <= 1'b0;
      hold1_data_q  <= '0;
      hold1_valid_q <= 1'b0;
    end else begin
      unique case (phase_q)
        PhCapture: begin
          phase_q       <= PhEmit;
          data_out      <= valid_in0 ? data_in0 : IdleWord;
          valid_out     <= valid_in0;
          lane_out      <= 1'b0;
          hold1_data_q  <= data_in1;
          hold1_valid_q <= valid_in1;
        end
        PhEmit: begin
          phase_q   <= PhCapture;
          data_out  <= hold1_valid_q ? hold1_data_q : IdleWord;
          valid_out <= hold1_valid_q;
          lane_out  <= 1'b1;
        end
        default: phase_q <= PhCapture;
      endcase
    end
  end

  idle_detector #(
    .IDLE_PAIRS (IDLE_PAIRS)
  ) u_idle_detector (
    .clk_4f (clk_4f),
    .reset  (reset),
    .strobe (capture),
    .active (valid_in0 | valid_in1),
    .idle   (idle_out)
  );

endmodule

// File: tb/tb_mux_l2_tx.sv
// Directed bench for mux_l2_tx: reset, interleaving, invalid-lane masking, idle detection.
module tb_mux_l2_tx;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] data_in0;
  logic       valid_in0;
  logic [7:0] data_in1;
  logic       valid_in1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       lane_out;
  logic       idle_out;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk_4f = ~clk_4f;

  mux_l2_tx #(
    .WIDTH      (8),
    .IDLE_PAIRS (4)
  ) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in0  (data_in0),
    .valid_in0 (valid_in0),
    .data_in1  (data_in1),
    .valid_in1 (valid_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_out  (lane_out),
    .idle_out  (idle_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample just after it
  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic v,
                           input logic l, input logic i);
    check({tag, ".data"}, {24'd0, data_out}, {24'd0, d});
    check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    check({tag, ".lane"}, {31'd0, lane_out}, {31'd0, l});
    check({tag, ".idle"}, {31'd0, idle_out}, {31'd0, i});
  endtask

  task automatic drive(input logic [7:0] d0, input logic v0, input logic [7:0] d1,
                       input logic v1);
    data_in0  = d0;
    valid_in0 = v0;
    data_in1  = d1;
    valid_in1 = v1;
  endtask

  initial begin
    logic exp_idle [5];
    exp_idle = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b0;
    drive(8'h5A, 1'b1, 8'hA5, 1'b1);
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("reset", 8'h00, 1'b0, 1'b0, 1'b1);
    end

    // First released edge must be a capture edge
    reset = 1'b1;
    drive(8'hFF, 1'b1, 8'hEE, 1'b1);
    tick();
    check_out("ffee_e0", 8'hFF, 1'b1, 1'b0, 1'b0);
    drive(8'h13, 1'b1, 8'h31, 1'b1);
    tick();
    check_out("ffee_e1", 8'hEE, 1'b1, 1'b1, 1'b0);

    drive(8'hBB, 1'b1, 8'h77, 1'b0);
    tick();
    check_out("bb77_e0", 8'hBB, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("bb77_e1", 8'h00, 1'b0, 1'b1, 1'b0);

    // Invalid lanes carry nonzero raw data to catch leakage
    drive(8'h12, 1'b0, 8'h34, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("idle_e0_%0d", i), 8'h00, 1'b0, 1'b0, exp_idle[i]);
      tick();
      check_out($sformatf("idle_e1_%0d", i), 8'h00, 1'b0, 1'b1, exp_idle[i]);
    end

    drive(8'h00, 1'b0, 8'h99, 1'b1);
    tick();
    check_out("lane1_only_e0", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("lane1_only_e1", 8'h99, 1'b1, 1'b1, 1'b0);

    drive(8'hAA, 1'b1, 8'hAA, 1'b1);
    tick();
    check_out("aa_e0", 8'hAA, 1'b1, 1'b0, 1'b0);
    drive(8'h55, 1'b1, 8'h55, 1'b1);
    tick();
    check_out("aa_e1", 8'hAA, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("55_e0", 8'h55, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("55_e1", 8'h55, 1'b1, 1'b1, 1'b0);

    // Reset on the emit edge must drop the pending lane-1 byte
    drive(8'h11, 1'b1, 8'hCC, 1'b1);
    tick();
    check_out("cc_e0", 8'h11, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_out("cc_reset", 8'h00, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    drive(8'h22, 1'b1, 8'h33, 1'b1);
    tick();
    check_out("post_rst_e0", 8'h22, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("post_rst_e1", 8'h33, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
